// File: rtl/ifq_prefetch_pkg.sv
// Shared types and constants for the instruction prefetch queue.
package ifq_prefetch_pkg;

    // Maximum number of fetches in flight at any time.
    localparam int IFQ_MAX_OUT = 2;

    // One queued halfword: the instruction bits plus the bus-error tag of its fetch.
    typedef struct packed {
        logic [15:0] inst;
        logic        err;
    } IqEnt;

    // Bundle of everything presented to the decoder.
    typedef struct packed {
        logic        v;
        logic [15:0] inst;
        logic [31:0] pc;
        logic        err;
    } IfqO;

endpackage

// File: rtl/ifq_prefetch_ram.sv
// Halfword storage for the prefetch queue: HW write lanes, one asynchronous read port.
// Flop-based, data is never reset; validity is tracked by the level counter.
module ifq_prefetch_ram
    import ifq_prefetch_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int HW    = 2,
    parameter int AW    = 2
) (
    input  logic                   clk,
    input  logic [HW-1:0]          i_we,
    input  logic [HW-1:0][AW-1:0]  i_waddr,
    input  IqEnt [HW-1:0]          i_wdata,
    input  logic [AW-1:0]          i_raddr,
    output IqEnt                   o_rdata
);

    IqEnt r_mem [DEPTH];

    // Lane writes; the lanes of one response always target distinct entries.
    always_ff @(posedge clk) begin
        for (int li = 0; li < HW; li++) begin
            if (i_we[li]) begin
                r_mem[i_waddr[li]] <= i_wdata[li];
            end
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/ifq_prefetch.sv
// Instruction prefetch queue: issues FW-bit fetches, queues halfwords and feeds
// one 16-bit instruction per cycle with its PC to the decoder.
module ifq_prefetch
    import ifq_prefetch_pkg::*;
#(
    parameter int FW    = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic [31:0]              flush_pc,
    input  logic                     fetch_en,
    output logic                     if_req,
    output logic [31:0]              if_addr,
    input  logic                     if_ack,
    input  logic                     rsp_valid,
    input  logic [FW-1:0]            rsp_data,
    input  logic                     rsp_err,
    output logic                     id_valid,
    output logic [15:0]              id_inst,
    output logic [31:0]              id_pc,
    output logic                     id_err,
    input  logic                     id_take,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int HW = FW / 16;           // halfwords per fetch
    localparam int AW = $clog2(DEPTH);     // queue pointer width
    localparam int LW = AW + 1;            // level width
    localparam int OB = $clog2(FW / 8);    // byte-offset bits inside one fetch
    localparam int SW = OB - 1;            // width of the leading-halfword skip count
    localparam int CW = LW + 2;            // headroom for the space-reservation sum

    // State
    logic [31:OB]    r_fpc;        // fetch pc, kept fetch-aligned
    logic [1:0]      r_out;        // requests issued but not yet answered
    logic [1:0]      r_disc;       // responses still to be thrown away after a redirect
    logic [LW-1:0]   r_level;
    logic [AW-1:0]   r_wptr;
    logic [AW-1:0]   r_rptr;
    logic [31:0]     r_hpc;        // pc of the head halfword
    logic            r_skip_pend;  // next written response is the first after a redirect
    logic [SW-1:0]   r_skip;       // leading halfwords to drop from that response

    // Combinational
    logic [CW-1:0]         w_need;
    logic                  w_issue;
    logic                  w_take;
    logic                  w_rsp_drop;
    logic                  w_rsp_wr;
    logic [SW-1:0]         w_skip;
    logic [LW-1:0]         w_wr_cnt;
    logic                  w_valid;
    logic [15:0]           w_hw [HW];
    logic [HW-1:0]         w_we;
    logic [HW-1:0][AW-1:0] w_waddr;
    IqEnt [HW-1:0]         w_wdata;
    IqEnt                  w_rdata;
    IfqO                   w_ifo;

    // Space needed if one more fetch were issued: current entries plus every in-flight response.
    assign w_need = CW'(r_level) + CW'(r_out) * CW'(HW) + CW'(HW);

    assign if_req  = rst_n & fetch_en & ~flush
                   & (r_out < 2'(IFQ_MAX_OUT))
                   & (w_need <= CW'(DEPTH));
    assign if_addr = {r_fpc, {OB{1'b0}}};

    assign w_issue    = if_req & if_ack;
    assign w_take     = id_take & w_valid & ~flush;
    assign w_rsp_drop = rsp_valid & (r_disc != 2'd0);
    assign w_rsp_wr   = rsp_valid & (r_disc == 2'd0) & ~flush;
    assign w_skip     = r_skip_pend ? r_skip : '0;
    assign w_wr_cnt   = w_rsp_wr ? (LW'(HW) - LW'(w_skip)) : '0;

    // Big-endian split of the fetch: halfword 0 sits in the top bits.
    for (genvar gi = 0; gi < HW; gi++) begin : g_hw
        assign w_hw[gi] = rsp_data[FW-1-16*gi -: 16];
    end

    // Lane gi writes source halfword gi+skip to tail+gi; dropped leading halfwords shift the rest down.
    for (genvar gi = 0; gi < HW; gi++) begin : g_lane
        logic [SW:0] w_src;
        assign w_src        = (SW+1)'(gi) + {1'b0, w_skip};
        assign w_we[gi]     = w_rsp_wr & (w_src < (SW+1)'(HW));
        assign w_waddr[gi]  = r_wptr + AW'(gi);
        assign w_wdata[gi]  = IqEnt'{inst: w_hw[w_src[SW-1:0]], err: rsp_err};
    end

    ifq_prefetch_ram #(
        .DEPTH (DEPTH),
        .HW    (HW),
        .AW    (AW)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr (w_waddr),
        .i_wdata (w_wdata),
        .i_raddr (r_rptr),
        .o_rdata (w_rdata)
    );

    // Head is presented straight from storage; stale storage is masked while empty.
    assign w_valid = (r_level != '0);
    assign w_ifo   = IfqO'{v:    w_valid,
                           inst: w_valid ? w_rdata.inst : 16'h0,
                           pc:   r_hpc,
                           err:  w_valid & w_rdata.err};

    assign id_valid = w_ifo.v;
    assign id_inst  = w_ifo.inst;
    assign id_pc    = w_ifo.pc;
    assign id_err   = w_ifo.err;
    assign level    = r_level;

    // Pointer, level, in-flight, discard and pc bookkeeping; redirect overrides take and write.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_fpc       <= '0;
            r_out       <= 2'd0;
            r_disc      <= 2'd0;
            r_level     <= '0;
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_hpc       <= 32'h0;
            r_skip_pend <= 1'b0;
            r_skip      <= '0;
        end else if (flush) begin
            r_level     <= '0;
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_fpc       <= flush_pc[31:OB];
            r_hpc       <= {flush_pc[31:1], 1'b0};
            // Everything still in flight is stale; a response landing now is dropped too.
            r_out       <= r_out - {1'b0, rsp_valid};
            r_disc      <= r_out - {1'b0, rsp_valid};
            r_skip_pend <= 1'b1;
            r_skip      <= flush_pc[OB-1:1];
        end else begin
            r_level <= r_level - LW'(w_take) + w_wr_cnt;
            r_wptr  <= r_wptr + AW'(w_wr_cnt);
            if (w_take) begin
                r_rptr <= r_rptr + AW'(1);
                r_hpc  <= r_hpc + 32'd2;
            end
            if (w_issue) begin
                r_fpc <= r_fpc + 1'b1;
            end
            r_out <= r_out + {1'b0, w_issue} - {1'b0, rsp_valid};
            if (w_rsp_drop) begin
                r_disc <= r_disc - 2'd1;
            end
            if (w_rsp_wr) begin
                r_skip_pend <= 1'b0;
            end
        end
    end

    // Space is reserved before every issue, so the queue can never overfill.
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) r_level <= LW'(DEPTH));

endmodule

// File: tb/tb_ifq_prefetch.sv
// Self-checking bench for ifq_prefetch: FW=32/DEPTH=4 against a queue-level reference
// model with directed and random stimulus, plus an FW=64/DEPTH=8 instance for
// outstanding-limit, saturation and mid-operation reset behaviour.
module tb_ifq_prefetch;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // FW=32, DEPTH=4 instance
    logic        rst_n, flush, fetch_en, if_ack, rsp_valid, rsp_err, id_take;
    logic [31:0] flush_pc, rsp_data;
    logic        if_req, id_valid, id_err;
    logic [31:0] if_addr, id_pc;
    logic [15:0] id_inst;
    logic [2:0]  level;

    // FW=64, DEPTH=8 instance
    logic        b_rst_n, b_flush, b_fe, b_ack, b_rv, b_err, b_take;
    logic [31:0] b_fpc_in;
    logic [63:0] b_data;
    logic        b_req, b_valid, b_id_err;
    logic [31:0] b_addr, b_pc;
    logic [15:0] b_inst;
    logic [3:0]  b_level;

    ifq_prefetch #(.FW(32), .DEPTH(4)) u_dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .flush_pc(flush_pc), .fetch_en(fetch_en),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .id_valid(id_valid), .id_inst(id_inst), .id_pc(id_pc), .id_err(id_err),
        .id_take(id_take), .level(level)
    );

    ifq_prefetch #(.FW(64), .DEPTH(8)) u_dut64 (
        .clk(clk), .rst_n(b_rst_n), .flush(b_flush), .flush_pc(b_fpc_in), .fetch_en(b_fe),
        .if_req(b_req), .if_addr(b_addr), .if_ack(b_ack),
        .rsp_valid(b_rv), .rsp_data(b_data), .rsp_err(b_err),
        .id_valid(b_valid), .id_inst(b_inst), .id_pc(b_pc), .id_err(b_id_err),
        .id_take(b_take), .level(b_level)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Memory image: word 0x100 holds AAAA_BBBB, everything else is an address hash.
    function automatic logic [15:0] mem_hw(input logic [31:0] a);
        if (a[31:2] == 30'h40) return a[1] ? 16'hBBBB : 16'hAAAA;
        return a[15:0] ^ 16'h5A3C;
    endfunction

    // Reference model: instruction queue and list of in-flight fetches.
    typedef struct { logic [15:0] inst; logic [31:0] pc; logic err; } ent_t;
    typedef struct { logic [31:0] addr; bit stale; } req_t;
    ent_t        mq[$];
    req_t        fl[$];
    logic [31:0] m_fpc;   // next fetch pc
    logic [31:0] m_tgt;   // redirect target: halfwords below it are never queued

    // One clock of the 32-bit instance: drive inputs, compare outputs, advance the model.
    task automatic cyc(input bit f, input logic [31:0] fp, input bit en, input bit ack,
                       input bit take, input bit rv, input bit re);
        bit          exp_req, issue, rsp;
        req_t        r;
        ent_t        e;
        logic [31:0] a;
        rsp       = rv && (fl.size() != 0);
        flush     = f;
        flush_pc  = fp;
        fetch_en  = en;
        if_ack    = ack;
        id_take   = take;
        rsp_valid = rsp;
        rsp_data  = rsp ? {mem_hw(fl[0].addr), mem_hw(fl[0].addr + 32'd2)} : 32'h0;
        rsp_err   = rsp & re;
        #1;
        exp_req = en && !f && (fl.size() < 2) && (mq.size() + 2 * fl.size() + 2 <= 4);
        check("level", 32'(level), 32'(mq.size()));
        check("id_valid", 32'(id_valid), 32'(mq.size() != 0));
        if (mq.size() != 0) begin
            check("id_inst", 32'(id_inst), 32'(mq[0].inst));
            check("id_pc", id_pc, mq[0].pc);
            check("id_err", 32'(id_err), 32'(mq[0].err));
        end
        check("if_req", 32'(if_req), 32'(exp_req));
        if (exp_req) check("if_addr", if_addr, {m_fpc[31:2], 2'b00});
        issue = exp_req && ack;
        if (f) begin
            mq.delete();
            foreach (fl[i]) fl[i].stale = 1'b1;
            if (rsp) void'(fl.pop_front());
            m_fpc = fp;
            m_tgt = {fp[31:1], 1'b0};
        end else begin
            if (take && mq.size() != 0) void'(mq.pop_front());
            if (rsp) begin
                r = fl.pop_front();
                $display("rsp addr=0x%08h data=0x%08h err=%0d stale=%0d", r.addr, rsp_data, rsp_err, r.stale);
                if (!r.stale) begin
                    for (int k = 0; k < 2; k++) begin
                        a = r.addr + 32'(2 * k);
                        if (a >= m_tgt) begin
                            e.inst = mem_hw(a);
                            e.pc   = a;
                            e.err  = rsp_err;
                            mq.push_back(e);
                        end
                    end
                end
            end
            if (issue) begin
                r.addr  = {m_fpc[31:2], 2'b00};
                r.stale = 1'b0;
                fl.push_back(r);
                m_fpc = m_fpc + 32'd4;
            end
        end
        @(negedge clk);
    endtask

    task automatic reset32();
        rst_n = 1'b0; flush = 1'b0; fetch_en = 1'b0; if_ack = 1'b0; id_take = 1'b0;
        rsp_valid = 1'b0; rsp_err = 1'b0; rsp_data = 32'h0; flush_pc = 32'h0;
        @(negedge clk);
        #1;
        check("rst_level", 32'(level), 32'd0);
        check("rst_id_valid", 32'(id_valid), 32'd0);
        check("rst_id_inst", 32'(id_inst), 32'd0);
        check("rst_id_pc", id_pc, 32'd0);
        check("rst_id_err", 32'(id_err), 32'd0);
        check("rst_if_req", 32'(if_req), 32'd0);
        mq.delete();
        fl.delete();
        m_fpc = 32'h0;
        m_tgt = 32'h0;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        int          b_iss;
        logic [31:0] b_addrs [2];

        b_rst_n = 1'b0; b_flush = 1'b0; b_fe = 1'b0; b_ack = 1'b0; b_rv = 1'b0;
        b_err = 1'b0; b_take = 1'b0; b_fpc_in = 32'h0; b_data = 64'h0;
        reset32();
        check("b_rst_level", 32'(b_level), 32'd0);
        check("b_rst_valid", 32'(b_valid), 32'd0);
        b_rst_n = 1'b1;

        // Straight-line stream from 0x100 with the decoder always taking.
        $display("phase straight-line");
        cyc(1, 32'h100, 1, 1, 1, 0, 0);
        repeat (14) cyc(0, 0, 1, 1, 1, 1, 0);

        // Odd start: only the low halfword of the first fetch is queued.
        $display("phase odd-start");
        cyc(1, 32'h102, 1, 0, 0, 0, 0);
        cyc(0, 0, 1, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 1, 0);
        check("odd_level", 32'(level), 32'd1);
        check("odd_inst", 32'(id_inst), 32'h0000BBBB);
        check("odd_pc", id_pc, 32'h102);
        cyc(0, 0, 0, 0, 0, 0, 0);

        // Error tagging on the fetch of 0x300.
        $display("phase error");
        cyc(1, 32'h300, 1, 0, 0, 0, 0);
        cyc(0, 0, 1, 1, 0, 0, 0);
        cyc(0, 0, 1, 1, 0, 1, 1);
        cyc(0, 0, 0, 0, 0, 1, 0);
        check("err_300", {id_pc[15:0], 15'h0, id_err}, {16'h0300, 16'h0001});
        cyc(0, 0, 0, 0, 1, 0, 0);
        check("err_302", {id_pc[15:0], 15'h0, id_err}, {16'h0302, 16'h0001});
        cyc(0, 0, 0, 0, 1, 0, 0);
        check("err_304", {id_pc[15:0], 15'h0, id_err}, {16'h0304, 16'h0000});

        // Redirect with two fetches in flight: both stale responses vanish.
        $display("phase flush-mid-flight");
        cyc(1, 32'h180, 1, 0, 0, 0, 0);
        cyc(0, 0, 1, 1, 0, 0, 0);
        cyc(0, 0, 1, 1, 0, 0, 0);
        cyc(1, 32'h200, 1, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 0, 1, 0);
        check("flush_stale_level", 32'(level), 32'd0);
        cyc(0, 0, 1, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 1, 0);
        check("flush_pc", id_pc, 32'h200);
        check("flush_inst", 32'(id_inst), 32'(mem_hw(32'h200)));

        // Backpressure: no takes, queue fills and requests stop.
        $display("phase backpressure");
        cyc(1, 32'h400, 1, 1, 0, 0, 0);
        repeat (6) cyc(0, 0, 1, 1, 0, 1, 0);
        check("bp_level", 32'(level), 32'd4);
        check("bp_if_req", 32'(if_req), 32'd0);

        // Random traffic.
        $display("phase random");
        for (int i = 0; i < 600; i++) begin
            cyc(($urandom % 16) == 0, 32'h1000 + 32'(2 * $urandom_range(0, 127)),
                ($urandom % 8) != 0, ($urandom % 4) != 0, ($urandom % 3) != 0,
                ($urandom % 2) == 0, ($urandom % 8) == 0);
        end

        // Reset in the middle of traffic; late responses are not driven.
        $display("phase reset-mid-op");
        reset32();
        for (int i = 0; i < 100; i++) begin
            cyc(($urandom % 16) == 0, 32'h2000 + 32'(2 * $urandom_range(0, 127)),
                ($urandom % 8) != 0, ($urandom % 4) != 0, ($urandom % 3) != 0,
                ($urandom % 2) == 0, ($urandom % 8) == 0);
        end
        flush = 1'b0; fetch_en = 1'b0; if_ack = 1'b0; id_take = 1'b0; rsp_valid = 1'b0;

        // FW=64, DEPTH=8: never more than two fetches in flight.
        $display("phase fw64");
        b_iss = 0;
        b_addrs[0] = 32'hFFFF_FFFF;
        b_addrs[1] = 32'hFFFF_FFFF;
        b_fe = 1'b1; b_ack = 1'b1;
        for (int c = 0; c < 6; c++) begin
            #1;
            if (b_req) begin
                if (b_iss < 2) b_addrs[b_iss] = b_addr;
                b_iss++;
                $display("b issue addr=0x%08h", b_addr);
            end
            @(negedge clk);
        end
        check("b_issues", 32'(b_iss), 32'd2);
        check("b_addr0", b_addrs[0], 32'h0);
        check("b_addr1", b_addrs[1], 32'h8);
        b_rv = 1'b1;
        b_data = {mem_hw(32'h0), mem_hw(32'h2), mem_hw(32'h4), mem_hw(32'h6)};
        @(negedge clk);
        #1;
        check("b_level_4", 32'(b_level), 32'd4);
        check("b_req_4", 32'(b_req), 32'd0);
        b_data = {mem_hw(32'h8), mem_hw(32'hA), mem_hw(32'hC), mem_hw(32'hE)};
        @(negedge clk);
        b_rv = 1'b0;
        #1;
        check("b_level_8", 32'(b_level), 32'd8);
        check("b_req_8", 32'(b_req), 32'd0);
        check("b_inst_0", 32'(b_inst), 32'(mem_hw(32'h0)));
        check("b_pc_0", b_pc, 32'h0);
        b_fe = 1'b0; b_take = 1'b1;
        repeat (5) @(negedge clk);
        b_take = 1'b0; b_fe = 1'b1;
        #1;
        check("b_level_3", 32'(b_level), 32'd3);
        check("b_pc_a", b_pc, 32'hA);
        check("b_inst_a", 32'(b_inst), 32'(mem_hw(32'hA)));
        check("b_req_3", 32'(b_req), 32'd1);
        check("b_addr_10", b_addr, 32'h10);
        @(negedge clk);
        // Level 3 with one fetch in flight: reset now.
        b_rst_n = 1'b0;
        @(negedge clk);
        #1;
        check("b_rst_level", 32'(b_level), 32'd0);
        check("b_rst_valid", 32'(b_valid), 32'd0);
        check("b_rst_req", 32'(b_req), 32'd0);
        b_rst_n = 1'b1;
        #1;
        check("b_post_rst_req", 32'(b_req), 32'd1);
        check("b_post_rst_addr", b_addr, 32'h0);
        b_fe = 1'b0; b_ack = 1'b0;
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
